// File: rtl/alu_pkg.sv
// Shared ALU definitions: selection codes, aluop/funct encodings, the
// forwarding-source enum and the ID/EX stage register layout.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_src_e;

  typedef struct packed {
    logic        valid;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic        alusrc;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dest;
    logic        regwrite;
  } id_ex_t;

  // Newer producer (EX/MEM) wins; register 0 is hard-wired and never forwarded.
  function automatic fwd_src_e fwd_source(
    input logic [4:0] addr,
    input logic       exmem_rw,
    input logic [4:0] exmem_dst,
    input logic       memwb_rw,
    input logic [4:0] memwb_dst
  );
    if (exmem_rw && (exmem_dst != 5'd0) && (exmem_dst == addr)) return FWD_EXMEM;
    if (memwb_rw && (memwb_dst != 5'd0) && (memwb_dst == addr)) return FWD_MEMWB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: maps aluop/funct to ALU selection lines and
// flags R-type funct codes the ALU does not implement.
module alu_control
  import alu_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_sel_o,
  output logic       illegal_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    alu_sel_o = ALU_ADD;
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alu_sel_o = ALU_ADD;
      ALUOP_SUB: alu_sel_o = ALU_SUB;
      ALUOP_OR:  alu_sel_o = ALU_OR;
      default: begin
        case (funct_i)
          FUNCT_ADD: alu_sel_o = ALU_ADD;
          FUNCT_SUB: alu_sel_o = ALU_SUB;
          FUNCT_AND: alu_sel_o = ALU_AND;
          FUNCT_OR:  alu_sel_o = ALU_OR;
          FUNCT_SLT: alu_sel_o = ALU_SLT;
          default:   illegal_o = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control, operand forwarding
// from EX/MEM and MEM/WB, and ALU control decode.
module id_ex_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  in_aluop,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  input  logic [15:0] in_imm,
  input  logic        in_alusrc,
  input  logic [4:0]  in_rs_addr,
  input  logic [4:0]  in_rt_addr,
  input  logic [4:0]  in_dest,
  input  logic        in_regwrite,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_dest,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_dest,
  input  logic [31:0] memwb_result,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_sel,
  output logic        out_valid,
  output logic [4:0]  out_dest,
  output logic        out_regwrite,
  output logic [31:0] out_store_data,
  output logic        out_illegal
);

  id_ex_t   stage_q, stage_d;
  fwd_src_e src_a, src_b;
  logic [31:0] op_a, op_b;
  logic        illegal_raw;

  // Flush beats stall: a bubble is all-zero, including valid and regwrite.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid    = in_valid;
      stage_d.aluop    = in_aluop;
      stage_d.funct    = in_funct;
      stage_d.rs_val   = in_rs_val;
      stage_d.rt_val   = in_rt_val;
      stage_d.imm      = in_imm;
      stage_d.alusrc   = in_alusrc;
      stage_d.rs_addr  = in_rs_addr;
      stage_d.rt_addr  = in_rt_addr;
      stage_d.dest     = in_dest;
      stage_d.regwrite = in_regwrite;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign src_a = fwd_source(stage_q.rs_addr, exmem_regwrite, exmem_dest,
                            memwb_regwrite, memwb_dest);
  assign src_b = fwd_source(stage_q.rt_addr, exmem_regwrite, exmem_dest,
                            memwb_regwrite, memwb_dest);

  always_comb begin
    case (src_a)
      FWD_EXMEM: op_a = exmem_result;
      FWD_MEMWB: op_a = memwb_result;
      default:   op_a = stage_q.rs_val;
    endcase
    case (src_b)
      FWD_EXMEM: op_b = exmem_result;
      FWD_MEMWB: op_b = memwb_result;
      default:   op_b = stage_q.rt_val;
    endcase
  end

  alu_control u_alu_control (
    .aluop_i   (stage_q.aluop),
    .funct_i   (stage_q.funct),
    .alu_sel_o (alu_sel),
    .illegal_o (illegal_raw)
  );

  assign alu_in1        = op_a;
  assign alu_in2        = stage_q.alusrc ? {{16{stage_q.imm[15]}}, stage_q.imm} : op_b;
  assign out_store_data = op_b;
  assign out_valid      = stage_q.valid;
  assign out_dest       = stage_q.dest;
  assign out_regwrite   = stage_q.regwrite & stage_q.valid;
  assign out_illegal    = illegal_raw & stage_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic [31:0] in_rs_val, in_rt_val;
  logic [15:0] in_imm;
  logic        in_alusrc;
  logic [4:0]  in_rs_addr, in_rt_addr, in_dest;
  logic        in_regwrite;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_dest, memwb_dest;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_in1, alu_in2, out_store_data;
  logic [3:0]  alu_sel;
  logic        out_valid, out_regwrite, out_illegal;
  logic [4:0]  out_dest;

  int errors = 0;
  int checks = 0;

  // Model of what the stage currently holds.
  logic        m_valid, m_alusrc, m_rw;
  logic [1:0]  m_aluop;
  logic [5:0]  m_funct;
  logic [31:0] m_rs, m_rt;
  logic [15:0] m_imm;
  logic [4:0]  m_rsa, m_rta, m_dest;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_rs_val(in_rs_val),
    .in_rt_val(in_rt_val), .in_imm(in_imm), .in_alusrc(in_alusrc),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_dest(in_dest),
    .in_regwrite(in_regwrite), .exmem_regwrite(exmem_regwrite),
    .exmem_dest(exmem_dest), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_dest(memwb_dest),
    .memwb_result(memwb_result), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_sel(alu_sel), .out_valid(out_valid), .out_dest(out_dest),
    .out_regwrite(out_regwrite), .out_store_data(out_store_data),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_valid = 0; m_alusrc = 0; m_rw = 0; m_aluop = 0; m_funct = 0;
    m_rs = 0; m_rt = 0; m_imm = 0; m_rsa = 0; m_rta = 0; m_dest = 0;
  endtask

  // One rising edge; the model applies reset > flush > stall > capture.
  task automatic step();
    @(posedge clk);
    if (rst || flush) model_clear();
    else if (!stall) begin
      m_valid = in_valid; m_alusrc = in_alusrc; m_rw = in_regwrite;
      m_aluop = in_aluop; m_funct = in_funct; m_rs = in_rs_val;
      m_rt = in_rt_val; m_imm = in_imm; m_rsa = in_rs_addr;
      m_rta = in_rt_addr; m_dest = in_dest;
    end
    #1;
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rv);
    if (a == 0) return rv;
    if (exmem_regwrite && exmem_dest == a) return exmem_result;
    if (memwb_regwrite && memwb_dest == a) return memwb_result;
    return rv;
  endfunction

  function automatic logic [3:0] exp_sel();
    if (m_aluop == 2'b00) return 4'b0010;
    if (m_aluop == 2'b01) return 4'b0110;
    if (m_aluop == 2'b11) return 4'b0001;
    case (m_funct)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic exp_illegal();
    if (!m_valid || m_aluop != 2'b10) return 1'b0;
    return !(m_funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
  endfunction

  function automatic logic [31:0] exp_in2();
    if (m_alusrc) return {{16{m_imm[15]}}, m_imm};
    return fwd(m_rta, m_rt);
  endfunction

  task automatic clear_inputs();
    in_valid = 0; stall = 0; flush = 0; in_aluop = 0; in_funct = 0;
    in_rs_val = 0; in_rt_val = 0; in_imm = 0; in_alusrc = 0;
    in_rs_addr = 0; in_rt_addr = 0; in_dest = 0; in_regwrite = 0;
    exmem_regwrite = 0; exmem_dest = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_dest = 0; memwb_result = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    model_clear();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_regwrite !== 1'b0 || out_illegal !== 1'b0 ||
        alu_sel !== 4'b0010 || out_dest !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b rw=%b ill=%b sel=%b dest=%0d, want 0 0 0 0010 0",
               out_valid, out_regwrite, out_illegal, alu_sel, out_dest);
    end
    checks++;
    if (alu_in1 !== 0 || alu_in2 !== 0 || out_store_data !== 0) begin
      errors++;
      $display("FAIL reset_data: in1=%h in2=%h st=%h, want 0", alu_in1, alu_in2, out_store_data);
    end
    // Inputs asserted during reset must not load anything.
    in_valid = 1; in_regwrite = 1; in_dest = 5'd9; in_rs_val = 32'h1234;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_dest !== 5'd0 || alu_in1 !== 0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b dest=%0d in1=%h, want 0 0 0", out_valid, out_dest, alu_in1);
    end
    #2 rst = 0;
    clear_inputs();
  endtask

  task automatic test_add();
    in_valid = 1; in_aluop = 2'b10; in_funct = 6'b100000; in_rs_val = 5;
    in_rt_val = 7; in_rs_addr = 1; in_rt_addr = 2; in_dest = 4; in_regwrite = 1;
    step();
    checks++;
    if (alu_sel !== 4'b0010 || alu_in1 !== 32'd5 || alu_in2 !== 32'd7 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_path: sel=%b in1=%0d in2=%0d valid=%b, want 0010 5 7 1",
               alu_sel, alu_in1, alu_in2, out_valid);
    end
    checks++;
    if (out_regwrite !== 1'b1 || out_dest !== 5'd4 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL add_ctrl: rw=%b dest=%0d ill=%b, want 1 4 0", out_regwrite, out_dest, out_illegal);
    end
  endtask

  task automatic test_imm();
    in_alusrc = 1; in_imm = 16'hFFFE;
    step();
    checks++;
    if (alu_in2 !== 32'hFFFFFFFE || out_store_data !== 32'd7) begin
      errors++;
      $display("FAIL imm_path: in2=%h st=%h, want fffffffe 00000007", alu_in2, out_store_data);
    end
    in_imm = 16'h7FFF;
    step();
    checks++;
    if (alu_in2 !== 32'h00007FFF) begin
      errors++;
      $display("FAIL imm_pos: in2=%h, want 00007fff", alu_in2);
    end
    in_alusrc = 0;
  endtask

  task automatic test_forward();
    in_rs_addr = 3; in_rt_addr = 3; in_rs_val = 32'h11; in_rt_val = 32'h22;
    step();
    exmem_regwrite = 1; exmem_dest = 3; exmem_result = 32'hAA;
    memwb_regwrite = 1; memwb_dest = 3; memwb_result = 32'hBB;
    #1;
    checks++;
    if (alu_in1 !== 32'hAA || out_store_data !== 32'hAA) begin
      errors++;
      $display("FAIL fwd_exmem: in1=%h st=%h, want aa aa", alu_in1, out_store_data);
    end
    exmem_regwrite = 0;
    #1;
    checks++;
    if (alu_in1 !== 32'hBB || alu_in2 !== 32'hBB) begin
      errors++;
      $display("FAIL fwd_memwb: in1=%h in2=%h, want bb bb", alu_in1, alu_in2);
    end
    exmem_regwrite = 1; exmem_dest = 0; memwb_dest = 0;
    #1;
    checks++;
    if (alu_in1 !== 32'h11 || out_store_data !== 32'h22) begin
      errors++;
      $display("FAIL fwd_zero: in1=%h st=%h, want 11 22", alu_in1, out_store_data);
    end
    // Register 0 as source with matching dest 0 must still read rs_val.
    in_rs_addr = 0; in_rs_val = 32'h33;
    step();
    checks++;
    if (alu_in1 !== 32'h33) begin
      errors++;
      $display("FAIL fwd_r0: in1=%h, want 33", alu_in1);
    end
    clear_inputs();
  endtask

  task automatic test_stall_flush();
    logic [31:0] in1_ref, st_ref;
    in_valid = 1; in_regwrite = 1; in_dest = 5'd17; in_aluop = 2'b01;
    in_rs_val = 32'hDEAD; in_rt_val = 32'hBEEF; in_rs_addr = 6; in_rt_addr = 7;
    step();
    in1_ref = 32'hDEAD; st_ref = 32'hBEEF;
    stall = 1; in_valid = 0; in_dest = 5'd2; in_rs_val = 0; in_aluop = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_dest !== 5'd17 || alu_sel !== 4'b0110 ||
          alu_in1 !== in1_ref || out_store_data !== st_ref || out_regwrite !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b dest=%0d sel=%b in1=%h st=%h rw=%b",
                 i, out_valid, out_dest, alu_sel, alu_in1, out_store_data, out_regwrite);
      end
    end
    flush = 1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_regwrite !== 1'b0 || out_dest !== 5'd0 || alu_sel !== 4'b0010) begin
      errors++;
      $display("FAIL stall_flush: valid=%b rw=%b dest=%0d sel=%b, want 0 0 0 0010",
               out_valid, out_regwrite, out_dest, alu_sel);
    end
    clear_inputs();
  endtask

  task automatic test_illegal();
    in_valid = 1; in_aluop = 2'b10; in_funct = 6'b111111;
    step();
    checks++;
    if (out_illegal !== 1'b1 || alu_sel !== 4'b0010) begin
      errors++;
      $display("FAIL illegal: ill=%b sel=%b, want 1 0010", out_illegal, alu_sel);
    end
    in_valid = 0;
    step();
    checks++;
    if (out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_invalid: ill=%b, want 0", out_illegal);
    end
    in_valid = 1; in_funct = 6'b101010;
    step();
    checks++;
    if (out_illegal !== 1'b0 || alu_sel !== 4'b0111) begin
      errors++;
      $display("FAIL slt: ill=%b sel=%b, want 0 0111", out_illegal, alu_sel);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    in_valid = 1; in_regwrite = 1; in_aluop = 2'b01; in_dest = 5'd8; in_rs_val = 32'h5;
    step();
    stall = 1; flush = 1;
    #3 rst = 1;
    model_clear();
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_sel !== 4'b0010 || out_dest !== 5'd0 || out_regwrite !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b sel=%b dest=%0d rw=%b, want 0 0010 0 0",
               out_valid, alu_sel, out_dest, out_regwrite);
    end
    #1 rst = 0;
    flush = 0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_dest !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_stall: valid=%b dest=%0d, want 0 0", out_valid, out_dest);
    end
    stall = 0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_dest !== 5'd8 || alu_sel !== 4'b0110) begin
      errors++;
      $display("FAIL post_reset_load: valid=%b dest=%0d sel=%b, want 1 8 0110",
               out_valid, out_dest, alu_sel);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [5:0] legal [5];
    legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 300; n++) begin
      int pick;
      pick = int'($urandom_range(0, 5));
      in_valid   = 1'($urandom);
      stall      = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      in_aluop   = 2'($urandom);
      in_funct   = (pick < 5) ? legal[pick] : 6'($urandom);
      in_rs_val  = $urandom; in_rt_val = $urandom; in_imm = 16'($urandom);
      in_alusrc  = 1'($urandom);
      in_rs_addr = 5'($urandom_range(0, 3)); in_rt_addr = 5'($urandom_range(0, 3));
      in_dest    = 5'($urandom); in_regwrite = 1'($urandom);
      step();
      exmem_regwrite = 1'($urandom); exmem_dest = 5'($urandom_range(0, 3));
      exmem_result   = $urandom;
      memwb_regwrite = 1'($urandom); memwb_dest = 5'($urandom_range(0, 3));
      memwb_result   = $urandom;
      #1;
      checks++;
      if (out_valid !== m_valid || out_dest !== m_dest || out_regwrite !== (m_rw && m_valid) ||
          alu_sel !== exp_sel() || out_illegal !== exp_illegal()) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: v=%b d=%0d rw=%b sel=%b ill=%b, want %b %0d %b %b %b",
                 n, out_valid, out_dest, out_regwrite, alu_sel, out_illegal,
                 m_valid, m_dest, m_rw && m_valid, exp_sel(), exp_illegal());
      end
      checks++;
      if (alu_in1 !== fwd(m_rsa, m_rs) || alu_in2 !== exp_in2() ||
          out_store_data !== fwd(m_rta, m_rt)) begin
        errors++;
        $display("FAIL rand_data[%0d]: in1=%h in2=%h st=%h, want %h %h %h",
                 n, alu_in1, alu_in2, out_store_data,
                 fwd(m_rsa, m_rs), exp_in2(), fwd(m_rta, m_rt));
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_forward();
    test_stall_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset).
REQ-002 SHALL have in_valid input 1 (decode slot holds a real instruction); stall input 1 (hold stage contents); flush input 1 (replace next contents with a bubble).
REQ-003 SHALL have in_aluop input 2 (00 add, 01 sub, 10 R-type via funct, 11 or); in_funct input 6 (R-type funct field).
REQ-004 SHALL have in_rs_val and in_rt_val inputs, 32 bits each (register-file read data); in_imm input 16 (immediate field); in_alusrc input 1 (operand 2 = immediate).
REQ-005 SHALL have in_rs_addr, in_rt_addr and in_dest inputs, 5 bits each; in_regwrite input 1.
REQ-006 SHALL have forwarding inputs exmem_regwrite 1, exmem_dest 5, exmem_result 32, memwb_regwrite 1, memwb_dest 5 and memwb_result 32.
REQ-007 SHALL have ALU outputs alu_in1 32, alu_in2 32 and alu_sel 4 (ALU selection lines).
REQ-008 SHALL have outputs out_valid 1, out_dest 5, out_regwrite 1, out_store_data 32 (forwarded rt value) and out_illegal 1 (unknown funct).

Function
REQ-009 On each clk edge with flush=1, the stage SHALL load a bubble: valid=0, regwrite=0, all other fields 0; flush SHALL take priority over stall.
REQ-010 On each clk edge with flush=0 and stall=1, all stage registers SHALL hold.
REQ-011 Otherwise the stage SHALL capture all in_* fields; out_valid SHALL follow in_valid one cycle later.
REQ-012 out_regwrite SHALL be the registered in_regwrite ANDed with registered valid.
REQ-013 alu_sel SHALL be decoded from the registered aluop and funct: aluop 00 -> 0010; aluop 01 -> 0110; aluop 11 -> 0001.
REQ-014 For aluop 10, funct SHALL decode as: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111.
REQ-015 For aluop 10 with any other funct, alu_sel SHALL be 0010 and out_illegal SHALL be 1 when valid; out_illegal SHALL be 0 in all other cases.
REQ-016 Operand A (forwarded rs) SHALL be exmem_result when exmem_regwrite=1, exmem_dest!=0 and exmem_dest equals the registered rs_addr.
REQ-017 Otherwise operand A SHALL be memwb_result under the same rule applied to the memwb inputs, and otherwise the registered rs_val.
REQ-018 Operand B (forwarded rt) SHALL be selected by the same rule against the registered rt_addr; a match on EX/MEM SHALL take precedence over MEM/WB.
REQ-019 alu_in1 SHALL equal operand A.
REQ-020 alu_in2 SHALL be the sign-extended registered imm (bit 15 replicated to bits 31:16) when alusrc=1, else operand B.
REQ-021 out_store_data SHALL always equal operand B.
REQ-022 Forwarding muxes SHALL be combinational from registered fields and live forwarding inputs, adding zero cycles of latency.
REQ-023 Register address 0 SHALL never be a forwarding source, even when regwrite is set.

Reset
REQ-024 While rst=1, all stage registers SHALL clear to 0 immediately, independent of clk.
REQ-025 With all registers cleared, outputs SHALL be: out_valid=0, out_regwrite=0, out_illegal=0, alu_sel=0010, out_dest=0; alu_in1, alu_in2 and out_store_data SHALL be 0 unless forwarding to register 0, which is excluded by REQ-023.
REQ-026 Reset asserted mid-stall or mid-flush SHALL override both; the first edge after release SHALL obey REQ-009 to REQ-011.

Structure
REQ-027 The shared package alu_pkg SHALL hold: the 4-bit selection constants (AND, OR, ADD, SUB, SLT), the aluop encodings, the funct constants, and a forwarding-source enum (REG, EXMEM, MEMWB).
REQ-028 The funct/aluop decode SHALL be a sub-module named alu_control, purely combinational, reused by other datapath stages.

Verification
REQ-029 ADD path: aluop=10, funct=100000, rs_val=5, rt_val=7, no forwarding match -> next cycle alu_sel=0010, alu_in1=5, alu_in2=7, out_valid=1.
REQ-030 Immediate path: alusrc=1, imm=16'hFFFE -> alu_in2=32'hFFFFFFFE.
REQ-031 Forwarding priority: rs_addr=3 with exmem_dest=3 (result 0xAA) and memwb_dest=3 (result 0xBB), both regwrite=1 -> alu_in1=0xAA; exmem_regwrite=0 -> alu_in1=0xBB; dest=0 -> alu_in1=rs_val.
REQ-032 Stall/flush: stall=1 for 3 cycles -> outputs unchanged; stall=1 and flush=1 together -> out_valid=0 and out_regwrite=0 next cycle.
REQ-033 Illegal funct 111111 with aluop=10 -> out_illegal=1, alu_sel=0010.
REQ-034 Async reset: assert rst between clock edges -> out_valid=0 and alu_sel=0010 before the next edge.
